// File: rtl/top_earlgrey_pkg.sv
// Shared definitions for the top_earlgrey boot sequencer: FSM state encoding,
// boot ROM contents, the expected boot checksum and sequencing constants.
package top_earlgrey_pkg;

  // Encoding is visible on state_o, so values are fixed.
  typedef enum logic [2:0] {
    StRstHold = 3'd0,
    StBoot    = 3'd1,
    StCheck   = 3'd2,
    StRun     = 3'd3,
    StError   = 3'd4
  } state_e;

  localparam int unsigned RST_HOLD_CYCLES = 4;
  localparam int unsigned ROM_DEPTH       = 16;

  // Sum of all 16 ROM words, mod 2^32.
  localparam logic [31:0] BOOT_CHECKSUM = 32'h6A00_0078;

  // Constant boot ROM: word i = {16'hE6A0, 12'h000, i}.
  function automatic logic [31:0] boot_rom(input logic [3:0] addr);
    return {16'hE6A0, 12'h000, addr};
  endfunction

endpackage

// File: rtl/earlgrey_timer.sv
// Machine timer: prescaler, 64-bit mtime, compare and registered interrupt.
// Counts only while run_i is high; holds otherwise.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   run_i      count enable (sequencer in RUN)
//   mtime_o    current mtime value
//   irq_o      registered (run && mtime >= MTIMECMP)
module earlgrey_timer #(
  parameter int unsigned PRESCALE = 4,
  parameter logic [63:0] MTIMECMP = 64'd3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  output logic [63:0] mtime_o,
  output logic        irq_o
);

  logic [7:0]  prescale_q, prescale_d;
  logic [63:0] mtime_q, mtime_d;
  logic        irq_q, irq_d;

  always_comb begin
    prescale_d = prescale_q;
    mtime_d    = mtime_q;
    if (run_i) begin
      if (prescale_q == 8'(PRESCALE - 1)) begin
        prescale_d = '0;
        mtime_d    = mtime_q + 64'd1;  // wraps naturally at 2^64
      end else begin
        prescale_d = prescale_q + 8'd1;
      end
    end
    irq_d = run_i && (mtime_q >= MTIMECMP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescale_q <= '0;
      mtime_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      mtime_q    <= mtime_d;
      irq_q      <= irq_d;
    end
  end

  assign mtime_o = mtime_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/top_earlgrey.sv
// Boot sequencer top: holds reset for a few cycles, sums the boot ROM,
// checks the sum, then enters RUN where the timer and heartbeat operate.
// Optional feature macro TOP_EARLGREY_BOOT_CHECK_EN: when defined, a checksum
// mismatch in CHECK goes to ERROR; otherwise CHECK always goes to RUN and
// fatal_o is tied low.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   boot_done_o  high in RUN
//   fatal_o      high in ERROR
//   alive_o      heartbeat square wave in RUN, 0 elsewhere
//   irq_timer_o  timer interrupt level
//   mtime_o      machine timer value
//   checksum_o   running boot checksum
//   state_o      encoded FSM state
module top_earlgrey
  import top_earlgrey_pkg::*;
#(
  parameter int unsigned PRESCALE      = 4,
  parameter int unsigned HEARTBEAT_DIV = 8,
  parameter logic [63:0] MTIMECMP      = 64'd3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        boot_done_o,
  output logic        fatal_o,
  output logic        alive_o,
  output logic        irq_timer_o,
  output logic [63:0] mtime_o,
  output logic [31:0] checksum_o,
  output logic [2:0]  state_o
);

  state_e      state_q, state_d;
  logic [1:0]  hold_q, hold_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] checksum_q, checksum_d;
  logic [7:0]  hb_q, hb_d;
  logic        alive_q, alive_d;
  logic        boot_done_q, boot_done_d;
  logic        fatal_q, fatal_d;
  logic [31:0] rom_data;
  logic        run;

  assign run = (state_q == StRun);

  always_comb begin
    rom_data = boot_rom(addr_q);
  end

  // Sequencer next state.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    checksum_d = checksum_q;
    unique case (state_q)
      StRstHold: begin
        if (hold_q == 2'(RST_HOLD_CYCLES - 1)) state_d = StBoot;
        else hold_d = hold_q + 2'd1;
      end
      StBoot: begin
        checksum_d = checksum_q + rom_data;
        if (addr_q == 4'(ROM_DEPTH - 1)) state_d = StCheck;
        else addr_d = addr_q + 4'd1;
      end
      StCheck: begin
`ifdef TOP_EARLGREY_BOOT_CHECK_EN
        state_d = (checksum_q == BOOT_CHECKSUM) ? StRun : StError;
`else
        state_d = StRun;
`endif
      end
      StRun, StError: ;
      default: state_d = StRstHold;
    endcase
  end

  // Heartbeat and registered status flags, derived from the next state so
  // they line up with state_q.
  always_comb begin
    hb_d    = hb_q;
    alive_d = alive_q;
    if (run) begin
      if (hb_q == 8'(HEARTBEAT_DIV - 1)) begin
        hb_d    = '0;
        alive_d = ~alive_q;
      end else begin
        hb_d = hb_q + 8'd1;
      end
    end else begin
      hb_d    = '0;
      alive_d = 1'b0;
    end
    boot_done_d = (state_d == StRun);
`ifdef TOP_EARLGREY_BOOT_CHECK_EN
    fatal_d = (state_d == StError);
`else
    fatal_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRstHold;
      hold_q      <= '0;
      addr_q      <= '0;
      checksum_q  <= '0;
      hb_q        <= '0;
      alive_q     <= 1'b0;
      boot_done_q <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      checksum_q  <= checksum_d;
      hb_q        <= hb_d;
      alive_q     <= alive_d;
      boot_done_q <= boot_done_d;
      fatal_q     <= fatal_d;
    end
  end

  earlgrey_timer #(
    .PRESCALE (PRESCALE),
    .MTIMECMP (MTIMECMP)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (run),
    .mtime_o (mtime_o),
    .irq_o   (irq_timer_o)
  );

  assign boot_done_o = boot_done_q;
  assign fatal_o     = fatal_q;
  assign alive_o     = alive_q;
  assign checksum_o  = checksum_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_top_earlgrey.sv
module tb_top_earlgrey;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        boot_done, fatal, alive, irq;
  logic [63:0] mtime;
  logic [31:0] checksum;
  logic [2:0]  state;

  logic        w_boot_done, w_fatal, w_alive, w_irq;
  logic [63:0] w_mtime;
  logic [31:0] w_checksum;
  logic [2:0]  w_state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  top_earlgrey dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .boot_done_o (boot_done),
    .fatal_o     (fatal),
    .alive_o     (alive),
    .irq_timer_o (irq),
    .mtime_o     (mtime),
    .checksum_o  (checksum),
    .state_o     (state)
  );

  top_earlgrey #(
    .MTIMECMP (MAX64)
  ) dut_w (
    .clk_i       (clk),
    .rst_i       (rst),
    .boot_done_o (w_boot_done),
    .fatal_o     (w_fatal),
    .alive_o     (w_alive),
    .irq_timer_o (w_irq),
    .mtime_o     (w_mtime),
    .checksum_o  (w_checksum),
    .state_o     (w_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, release, and run 21 edges into RUN.
  task automatic do_boot();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (21) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors += 7;
    if (state !== 3'd0) begin miscompares++;
      $display("FAIL reset_state got %0d want 0", state); end
    if (boot_done !== 1'b0) begin miscompares++;
      $display("FAIL reset_boot_done got %b want 0", boot_done); end
    if (fatal !== 1'b0) begin miscompares++;
      $display("FAIL reset_fatal got %b want 0", fatal); end
    if (alive !== 1'b0) begin miscompares++;
      $display("FAIL reset_alive got %b want 0", alive); end
    if (irq !== 1'b0) begin miscompares++;
      $display("FAIL reset_irq got %b want 0", irq); end
    if (mtime !== 64'd0) begin miscompares++;
      $display("FAIL reset_mtime got %0h want 0", mtime); end
    if (checksum !== 32'd0) begin miscompares++;
      $display("FAIL reset_checksum got %h want 0", checksum); end
  endtask

  // Called with reset still asserted; walks edges 1..21 after release.
  task automatic test_boot();
    logic [2:0] exp_state;
    rst = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      tick();
      if (e <= 3) exp_state = 3'd0;
      else if (e <= 19) exp_state = 3'd1;
      else if (e == 20) exp_state = 3'd2;
      else exp_state = 3'd3;
      vectors += 2;
      if (state !== exp_state) begin miscompares++;
        $display("FAIL boot_state edge %0d got %0d want %0d", e, state, exp_state); end
      if (boot_done !== (e == 21)) begin miscompares++;
        $display("FAIL boot_done edge %0d got %b want %b", e, boot_done, e == 21); end
    end
    vectors += 2;
    if (checksum !== 32'h6A00_0078) begin miscompares++;
      $display("FAIL boot_checksum got %h want 6a000078", checksum); end
    if (fatal !== 1'b0) begin miscompares++;
      $display("FAIL boot_fatal got %b want 0", fatal); end
  endtask

  // Entered right after edge 21 (RUN entry).
  task automatic test_timer();
    logic [63:0] exp_mtime;
    logic        exp_irq;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_mtime = 64'(k / 4);
      exp_irq   = ((k - 1) / 4) >= 3;
      vectors += 2;
      if (mtime !== exp_mtime) begin miscompares++;
        $display("FAIL timer_mtime k=%0d got %0d want %0d", k, mtime, exp_mtime); end
      if (irq !== exp_irq) begin miscompares++;
        $display("FAIL timer_irq k=%0d got %b want %b", k, irq, exp_irq); end
    end
  endtask

  task automatic test_heartbeat();
    int   toggles;
    logic prev;
    logic exp_alive;
    do_boot();
    toggles = 0;
    prev = alive;
    vectors++;
    if (alive !== 1'b0) begin miscompares++;
      $display("FAIL hb_entry got %b want 0", alive); end
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_alive = ((k / 8) % 2) == 1;
      if (alive !== prev) toggles++;
      prev = alive;
      vectors++;
      if (alive !== exp_alive) begin miscompares++;
        $display("FAIL hb_alive k=%0d got %b want %b", k, alive, exp_alive); end
    end
    vectors += 2;
    if (toggles != 4) begin miscompares++;
      $display("FAIL hb_toggles got %0d want 4", toggles); end
    if (alive !== 1'b0) begin miscompares++;
      $display("FAIL hb_final got %b want 0", alive); end
  endtask

  task automatic test_reset_mid_boot();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (11) tick();  // BOOT now presenting address 7
    vectors += 2;
    if (state !== 3'd1) begin miscompares++;
      $display("FAIL mid_state got %0d want 1", state); end
    if (checksum !== 32'h4E60_0015) begin miscompares++;
      $display("FAIL mid_checksum got %h want 4e600015", checksum); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors += 4;
      if (state !== 3'd0) begin miscompares++;
        $display("FAIL abort_state i=%0d got %0d want 0", i, state); end
      if (checksum !== 32'd0) begin miscompares++;
        $display("FAIL abort_checksum i=%0d got %h want 0", i, checksum); end
      if (boot_done !== 1'b0 || fatal !== 1'b0 || alive !== 1'b0 || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_flags i=%0d got %b%b%b%b want 0000", i, boot_done, fatal,
                 alive, irq); end
      if (mtime !== 64'd0) begin miscompares++;
        $display("FAIL abort_mtime i=%0d got %0h want 0", i, mtime); end
    end
    test_boot();
  endtask

  task automatic test_wrap();
    logic [63:0] exp_m [8];
    logic        exp_i [8];
    exp_m = '{MAX64 - 1, MAX64 - 1, MAX64, MAX64, MAX64, MAX64, 64'd0, 64'd0};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_boot();
    force dut_w.u_timer.mtime_q = MAX64 - 1;
    tick();
    release dut_w.u_timer.mtime_q;
    for (int j = 0; j < 8; j++) begin
      tick();
      vectors += 2;
      if (w_mtime !== exp_m[j]) begin miscompares++;
        $display("FAIL wrap_mtime j=%0d got %h want %h", j, w_mtime, exp_m[j]); end
      if (w_irq !== exp_i[j]) begin miscompares++;
        $display("FAIL wrap_irq j=%0d got %b want %b", j, w_irq, exp_i[j]); end
    end
  endtask

`ifdef TOP_EARLGREY_BOOT_CHECK_EN
  task automatic test_boot_error();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();  // BOOT, address 0
    force dut.rom_data = 32'd0;
    tick();
    release dut.rom_data;
    repeat (16) tick();
    vectors += 5;
    if (state !== 3'd4) begin miscompares++;
      $display("FAIL err_state got %0d want 4", state); end
    if (fatal !== 1'b1) begin miscompares++;
      $display("FAIL err_fatal got %b want 1", fatal); end
    if (boot_done !== 1'b0) begin miscompares++;
      $display("FAIL err_boot_done got %b want 0", boot_done); end
    if (checksum !== 32'h8360_0078) begin miscompares++;
      $display("FAIL err_checksum got %h want 83600078", checksum); end
    repeat (10) tick();
    if (mtime !== 64'd0) begin miscompares++;
      $display("FAIL err_mtime got %0h want 0", mtime); end
  endtask
`endif

  initial begin
    test_reset();
    test_boot();
    test_timer();
    test_heartbeat();
    test_reset_mid_boot();
    test_wrap();
`ifdef TOP_EARLGREY_BOOT_CHECK_EN
    test_boot_error();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
